// File: rtl/ks_pkg.sv
// Shared types for the Kogge-Stone adder arbiter.
// Default sizes, FSM state encoding and response bundle.
package ks_pkg;

  localparam int KS_W    = 8;
  localparam int KS_NREQ = 4;
  localparam int ID_W    = $clog2(KS_NREQ);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [KS_W-1:0] sum;
    logic            cout;
    logic            last;
  } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit of req from ptr up.
// Ports: req, ptr in; one-hot gnt, encoded idx and any out.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] cand;

  // NREQ is a power of two, so the IW-bit add wraps modulo NREQ.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = ptr + IW'(i);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/ks_adder_arbiter.sv
// Shares one external W-bit adder among NREQ requesters with
// round-robin grant, carry-chained multi-byte lock and a
// registered valid/ready response.
// Ports: clk, rst (sync, high); req_* per-requester inputs and
// req_ready; add_* to/from the adder; rsp_* response port.
module ks_adder_arbiter
  import ks_pkg::*;
#(
  parameter int NREQ = KS_NREQ,
  parameter int W    = KS_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*W-1:0]       req_a,
  input  logic [NREQ*W-1:0]       req_b,
  input  logic [NREQ-1:0]         req_last,
  output logic [W-1:0]            add_a,
  output logic [W-1:0]            add_b,
  output logic                    add_cin,
  input  logic [W-1:0]            add_sum,
  input  logic                    add_cout,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [W-1:0]            rsp_sum,
  output logic                    rsp_cout,
  output logic                    rsp_last
);

  localparam int IW = $clog2(NREQ);

  state_e        state;
  logic [IW-1:0] lock_id;
  logic [IW-1:0] rr_ptr;
  logic          carry_q;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  logic [IW-1:0]   g_id;
  logic            g_vld;
  logic            can_issue;
  logic            accept;
  logic            locked;
  logic [NREQ-1:0] lock_hot;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign locked    = (state == LOCK);
  assign can_issue = ~rsp_valid | rsp_ready;
  assign lock_hot  = NREQ'(1) << lock_id;

  // A lock pins the grant even while its owner is idle.
  always_comb begin
    g_id  = locked ? lock_id : arb_idx;
    g_vld = ~rst & (locked | arb_any);
  end

  assign accept = g_vld & req_valid[g_id] & can_issue;

  // Ready only on a real transfer, so it is one-hot or zero.
  always_comb begin
    req_ready = '0;
    if (!rst && can_issue) begin
      if (locked)
        req_ready = lock_hot & req_valid;
      else
        req_ready = arb_gnt;
    end
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (g_vld) begin
      add_a   = req_a[g_id*W +: W];
      add_b   = req_b[g_id*W +: W];
      add_cin = locked & carry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lock_id   <= '0;
      rr_ptr    <= '0;
      carry_q   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_last  <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_id    <= g_id;
      rsp_sum   <= add_sum;
      rsp_cout  <= add_cout;
      rsp_last  <= req_last[g_id];
      if (req_last[g_id]) begin
        state   <= IDLE;
        rr_ptr  <= g_id + IW'(1);
        carry_q <= 1'b0;
      end else begin
        state   <= LOCK;
        lock_id <= g_id;
        carry_q <= add_cout;
      end
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ks_adder_arbiter.sv
// Randomised and directed bench for ks_adder_arbiter with a
// behavioural adder and a reference model of the arbiter.
module tb_ks_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_last;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_cin;
  logic [7:0]  add_sum;
  logic        add_cout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_sum;
  logic        rsp_cout;
  logic        rsp_last;

  ks_adder_arbiter #(
    .NREQ (4),
    .W    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_last  (req_last),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_last  (rsp_last)
  );

  always #5 clk = ~clk;

  logic [8:0] add_full;
  assign add_full = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
  assign add_sum  = add_full[7:0];
  assign add_cout = add_full[8];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  bit     m_lock;
  int     m_lid;
  int     m_ptr;
  int     m_carry;
  bit     m_rv;
  int     m_id;
  int     m_sum;
  int     m_cout;
  int     m_last;
  longint opa[4];
  longint opb[4];
  longint res[4];
  int     nb[4];
  logic   obs_cin;

  task automatic clr_op(int i);
    opa[i] = 0;
    opb[i] = 0;
    res[i] = 0;
    nb[i]  = 0;
  endtask

  task automatic mdl_reset();
    m_lock  = 0;
    m_lid   = 0;
    m_ptr   = 0;
    m_carry = 0;
    m_rv    = 0;
    m_id    = 0;
    m_sum   = 0;
    m_cout  = 0;
    m_last  = 0;
    for (int i = 0; i < 4; i++) clr_op(i);
  endtask

  task automatic put(int i, bit v, logic [7:0] a, logic [7:0] b, bit l);
    req_valid[i]     = v;
    req_a[i*8 +: 8]  = a;
    req_b[i*8 +: 8]  = b;
    req_last[i]      = l;
  endtask

  task automatic clear_all();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_last  = '0;
  endtask

  // One clock: check combinational outputs mid-cycle, then the
  // registered response just after the edge.
  task automatic step();
    int         g;
    bit         can;
    bit         acc;
    logic [3:0] er;
    int         ea;
    int         eb;
    int         ec;
    int         s;
    @(negedge clk);
    g = -1;
    if (!rst) begin
      if (m_lock) g = m_lid;
      else
        for (int i = 0; i < 4; i++) begin
          int j;
          j = (m_ptr + i) % 4;
          if (g < 0 && req_valid[j]) g = j;
        end
    end
    can = !m_rv || rsp_ready;
    acc = (g >= 0) && req_valid[g] && can;
    er  = acc ? 4'(1 << g) : 4'd0;
    ea  = (g >= 0) ? int'(req_a[g*8 +: 8]) : 0;
    eb  = (g >= 0) ? int'(req_b[g*8 +: 8]) : 0;
    ec  = (!rst && m_lock) ? m_carry : 0;
    chk("req_ready", req_ready, er);
    chk("add_a", add_a, ea);
    chk("add_b", add_b, eb);
    chk("add_cin", add_cin, ec);
    obs_cin = add_cin;
    s = ea + eb + ec;
    @(posedge clk);
    #1;
    if (rst) begin
      mdl_reset();
    end else if (acc) begin
      m_rv   = 1;
      m_id   = g;
      m_sum  = s % 256;
      m_cout = s / 256;
      m_last = req_last[g];
      opa[g] += longint'(ea) << (8 * nb[g]);
      opb[g] += longint'(eb) << (8 * nb[g]);
      if (m_last != 0) begin
        m_lock  = 0;
        m_ptr   = (g + 1) % 4;
        m_carry = 0;
      end else begin
        m_lock  = 1;
        m_lid   = g;
        m_carry = m_cout;
      end
    end else if (m_rv && rsp_ready) begin
      m_rv = 0;
    end
    chk("rsp_valid", rsp_valid, m_rv);
    chk("rsp_id", rsp_id, m_id);
    chk("rsp_sum", rsp_sum, m_sum);
    chk("rsp_cout", rsp_cout, m_cout);
    chk("rsp_last", rsp_last, m_last);
    if (!rst && acc) begin
      res[g] += longint'(rsp_sum) << (8 * nb[g]);
      nb[g]++;
      if (m_last != 0) begin
        res[g] += longint'(rsp_cout) << (8 * nb[g]);
        chk("multibyte", res[g], opa[g] + opb[g]);
        clr_op(g);
      end
    end
  endtask

  logic [1:0] held_id;
  logic [7:0] held_sum;

  initial begin
    mdl_reset();
    clear_all();
    rst       = 1'b1;
    rsp_ready = 1'b1;
    step();
    step();
    chk("rst_valid", rsp_valid, 0);
    rst = 1'b0;

    put(0, 1, 8'h5A, 8'h33, 1);
    step();
    chk("t1_valid", rsp_valid, 1);
    chk("t1_id", rsp_id, 0);
    chk("t1_sum", rsp_sum, 8'h8D);
    chk("t1_cout", rsp_cout, 0);
    chk("t1_last", rsp_last, 1);
    clear_all();
    step();

    put(2, 1, 8'hFF, 8'h01, 0);
    step();
    chk("ch0_sum", rsp_sum, 8'h00);
    chk("ch0_cout", rsp_cout, 1);
    put(2, 1, 8'h00, 8'h00, 1);
    step();
    chk("ch1_cin", obs_cin, 1);
    chk("ch1_sum", rsp_sum, 8'h01);
    chk("ch1_cout", rsp_cout, 0);
    clear_all();
    step();

    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++)
      put(i, 1, 8'($urandom), 8'($urandom), 1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("fair_valid", rsp_valid, 1);
      chk("fair_id", rsp_id, k % 4);
    end
    clear_all();
    step();

    put(1, 1, 8'h10, 8'h20, 0);
    step();
    chk("lk_id0", rsp_id, 1);
    put(1, 0, 8'h00, 8'h00, 0);
    put(0, 1, 8'h11, 8'h22, 1);
    put(3, 1, 8'h33, 8'h44, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("lk_block", req_ready, 4'd0);
    end
    put(1, 1, 8'h01, 8'h02, 1);
    step();
    chk("lk_id1", rsp_id, 1);
    put(1, 0, 8'h00, 8'h00, 0);
    step();
    chk("lk_next", rsp_id, 3);
    clear_all();
    step();

    for (int i = 0; i < 4; i++)
      put(i, 1, 8'($urandom), 8'($urandom), 1);
    step();
    held_id  = rsp_id;
    held_sum = rsp_sum;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_ready", req_ready, 4'd0);
      chk("bp_id", rsp_id, held_id);
      chk("bp_sum", rsp_sum, held_sum);
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_next", rsp_id, 2'(held_id + 1 + k));
    end
    clear_all();
    step();

    put(1, 1, 8'h01, 8'h01, 1);
    step();
    clear_all();
    step();
    put(1, 1, 8'h07, 8'h07, 0);
    step();
    put(1, 0, 8'h00, 8'h00, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rml_valid", rsp_valid, 0);
    put(1, 1, 8'h01, 8'h01, 1);
    put(3, 1, 8'h05, 8'h06, 1);
    step();
    chk("rml_cin", obs_cin, 0);
    chk("rml_id", rsp_id, 1);
    chk("rml_sum", rsp_sum, 8'h02);
    clear_all();
    step();

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++)
        put(i, $urandom_range(0, 99) < 60, 8'($urandom), 8'($urandom),
            (nb[i] >= 4) ? 1'b1 : 1'($urandom_range(0, 1)));
      rsp_ready = $urandom_range(0, 3) != 0;
      rst       = $urandom_range(0, 199) == 0;
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
